ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 195 +++++++++++++++++++
 tb/tb_ifetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Purpose: single-outstanding instruction fetch stage between the PC stage and decode.
// Latency: request on the edge after issue; instr_valid on the edge after imem_ack (minimum 2 cycles).
// Backpressure: stall holds the presented instruction and blocks new issues; an outstanding request is never withdrawn.
//
// Ports:
//   clk, reset                       clock; asynchronous active-low reset
//   ia                               fetch address from the PC stage
//   flush                            redirect: drop the in-flight or held instruction
//   stall                            decode not ready: hold instr/instr_pc/instr_valid
//   imem_req, imem_addr              memory request and its address (held until imem_ack)
//   imem_ack, imem_rdata             one-cycle response strobe and instruction word
//   instr, instr_pc, instr_valid     instruction presented to decode
//   fetch_done                       one-cycle PC-advance strobe per delivered instruction
//   fetch_err                        sticky fault (misaligned fetch or memory timeout)

module ifetch (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ia,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_done,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    state_t      state, state_nxt;
    logic        run;
    logic [7:0]  cnt, cnt_nxt;

    logic        imem_req_nxt;
    logic [31:0] imem_addr_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] instr_pc_nxt;
    logic        instr_valid_nxt;
    logic        fetch_done_nxt;
    logic        fetch_err_nxt;

    logic        issue_ok;
    logic        misaligned;
    logic        timeout;

    // Issuing only when the output slot is empty or being consumed guarantees
    // an ack can never overwrite a held instruction.
    assign issue_ok   = (!instr_valid || !stall) && !fetch_err;
    assign misaligned = (ia[1:0] != 2'b00);
    assign timeout    = (cnt == 8'hff);

    // State and output registers. 'run' delays the first state change after
    // reset release to the second rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            state       <= IDLE;
            cnt         <= 8'd0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= 32'h0000_0000;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_done  <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                state       <= state_nxt;
                cnt         <= cnt_nxt;
                imem_req    <= imem_req_nxt;
                imem_addr   <= imem_addr_nxt;
                instr       <= instr_nxt;
                instr_pc    <= instr_pc_nxt;
                instr_valid <= instr_valid_nxt;
                fetch_done  <= fetch_done_nxt;
                fetch_err   <= fetch_err_nxt;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_ok) begin
                    state_nxt = misaligned ? HALT : WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                end else if (timeout) begin
                    state_nxt = HALT;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                end else if (timeout) begin
                    state_nxt = HALT;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        cnt_nxt         = cnt;
        imem_req_nxt    = imem_req;
        imem_addr_nxt   = imem_addr;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        fetch_done_nxt  = 1'b0;
        fetch_err_nxt   = fetch_err;

        // Decode takes the held instruction whenever it is not stalling.
        if (instr_valid && !stall) begin
            instr_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (issue_ok) begin
                    if (misaligned) begin
                        fetch_err_nxt = 1'b1;
                    end else begin
                        imem_req_nxt  = 1'b1;
                        imem_addr_nxt = ia;
                        cnt_nxt       = 8'd0;
                    end
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    imem_req_nxt = 1'b0;
                    if (!flush) begin
                        instr_nxt       = imem_rdata;
                        instr_pc_nxt    = imem_addr;
                        instr_valid_nxt = 1'b1;
                        fetch_done_nxt  = 1'b1;
                    end
                end else if (timeout) begin
                    imem_req_nxt  = 1'b0;
                    fetch_err_nxt = 1'b1;
                end else begin
                    // The counter keeps running into DRAIN so the timeout
                    // bounds the whole lifetime of one outstanding request.
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    imem_req_nxt = 1'b0;
                end else if (timeout) begin
                    imem_req_nxt  = 1'b0;
                    fetch_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            HALT: begin
                imem_req_nxt    = 1'b0;
                instr_valid_nxt = 1'b0;
            end
            default: begin
                imem_req_nxt = 1'b0;
            end
        endcase

        // Flush wins over stall and over a same-cycle ack.
        if (flush) begin
            instr_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic [31:0] ia;
    logic        flush;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_done;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    // Expected {instr, instr_pc} for every ack driven without flush.
    logic [63:0] exp_q[$];

    ifetch dut (
        .clk        (clk),
        .reset      (reset),
        .ia         (ia),
        .flush      (flush),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   {31'd0, imem_req},    32'd0);
        check({tag, "_addr"},  imem_addr,            32'h8000_0000);
        check({tag, "_instr"}, instr,                32'h0000_0000);
        check({tag, "_pc"},    instr_pc,             32'h8000_0000);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_done"},  {31'd0, fetch_done},  32'd0);
        check({tag, "_err"},   {31'd0, fetch_err},   32'd0);
    endtask

    // Returns at a negedge where imem_req is high, or flags a timeout.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    // Fetch one word: wait for the request, delay the ack, push the expectation.
    // Ends on the negedge where the instruction is presented.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int dly);
        bit ok;
        ia = addr;
        wait_req(ok);
        if (ok) begin
            check("req_addr", imem_addr, addr);
            for (int i = 0; i < dly; i++) @(negedge clk);
            exp_q.push_back({data, addr});
            imem_ack   = 1'b1;
            imem_rdata = data;
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    // Scoreboard: every fetch_done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && fetch_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_instr", instr, e[63:32]);
                check("sb_pc",    instr_pc, e[31:0]);
                check("sb_valid", {31'd0, instr_valid}, 32'd1);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        logic [31:0] held_instr, held_pc;

        reset = 1'b0; ia = 32'h8000_0000; flush = 1'b0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Release: first state change on the second rising edge.
        reset = 1'b1;
        @(negedge clk);
        check("sync_edge1_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("sync_edge2_req", {31'd0, imem_req}, 32'd1);

        // Basic fetch with ack in the first request cycle.
        fetch_one(32'h8000_0000, 32'h2008_0005, 0);
        check("basic_valid", {31'd0, instr_valid}, 32'd1);
        check("basic_done",  {31'd0, fetch_done},  32'd1);
        stall = 1'b1;
        held_instr = instr;
        held_pc    = instr_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_instr", instr, held_instr);
            check("stall_pc",    instr_pc, held_pc);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_req",   {31'd0, imem_req}, 32'd0);
            check("stall_done",  {31'd0, fetch_done}, 32'd0);
        end
        ia = 32'h8000_0004;
        stall = 1'b0;
        @(negedge clk);
        check("unstall_req",   {31'd0, imem_req}, 32'd1);
        check("unstall_addr",  imem_addr, 32'h8000_0004);
        check("unstall_valid", {31'd0, instr_valid}, 32'd0);

        // Flush in WAIT, ack three cycles later: request held, data dropped.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_req", {31'd0, imem_req}, 32'd1);
            check("drain_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        check("drain_req_ack", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; ia = 32'h8000_0040;
        @(negedge clk);
        imem_ack = 1'b0;
        check("drain_done_req",   {31'd0, imem_req}, 32'd0);
        check("drain_done_valid", {31'd0, instr_valid}, 32'd0);
        check("drain_done_done",  {31'd0, fetch_done}, 32'd0);
        @(negedge clk);
        check("post_drain_req",  {31'd0, imem_req}, 32'd1);
        check("post_drain_addr", imem_addr, 32'h8000_0040);

        // Flush and ack in the same cycle.
        flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; ia = 32'h8000_0044;
        @(negedge clk);
        flush = 1'b0; imem_ack = 1'b0;
        check("fa_req",   {31'd0, imem_req}, 32'd0);
        check("fa_valid", {31'd0, instr_valid}, 32'd0);
        check("fa_done",  {31'd0, fetch_done}, 32'd0);
        fetch_one(32'h8000_0044, 32'h0010_0093, 0);

        // Back-to-back fetches with varying memory latency.
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'h8000_0100 + 32'(i * 4), $urandom, $urandom_range(0, 3));
        end

        // Flush overrides stall on a held instruction.
        stall = 1'b1;
        @(negedge clk);
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; stall = 1'b0;
        check("flush_stall_valid", {31'd0, instr_valid}, 32'd0);
        fetch_one(32'h8000_0110, 32'h1111_2222, 1);

        // Reset in the middle of WAIT: immediate reset values, reissue from ia.
        @(negedge clk);
        ia = 32'h8000_0200;
        wait_req(ok);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        ia = 32'h8000_0208;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_edge1_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("rel_req",  {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h8000_0208);
        fetch_one(32'h8000_0208, 32'h1234_5678, 0);

        // Misaligned fetch: sticky error, HALT, ack ignored.
        ia = 32'h8000_0002;
        @(negedge clk);
        check("mis_err", {31'd0, fetch_err}, 32'd1);
        check("mis_req", {31'd0, imem_req}, 32'd0);
        ia = 32'h8000_0210;
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i == 2);
            imem_rdata = 32'hBAD0_0000;
            @(negedge clk);
            check("halt_req",   {31'd0, imem_req}, 32'd0);
            check("halt_err",   {31'd0, fetch_err}, 32'd1);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_done",  {31'd0, fetch_done}, 32'd0);
        end
        imem_ack = 1'b0;

        // Memory timeout: request stays up for 256 sampled cycles, then HALT.
        reset = 1'b0;
        #1;
        check("rst2_err", {31'd0, fetch_err}, 32'd0);
        ia = 32'h8000_0300;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fetch_err) break;
            if (imem_req) n++;
        end
        check("to_err",    {31'd0, fetch_err}, 32'd1);
        check("to_req",    {31'd0, imem_req}, 32'd0);
        check("to_cycles", 32'(n), 32'd256);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
